// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: PS/2 pad lines in, decoded scan-code and held-key outputs.
interface ps2_key_decoder_if;
    logic       ps2Clk;
    logic       ps2Dat;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       isBreak;
    logic       isExtended;
    logic       frameError;
    logic       keyUp;
    logic       keyDown;
    logic       keyLeft;
    logic       keyRight;
    modport slave (
        input  ps2Clk, ps2Dat,
        output scanCode, scanValid, isBreak, isExtended, frameError,
        output keyUp, keyDown, keyLeft, keyRight
    );
    modport master (
        output ps2Clk, ps2Dat,
        input  scanCode, scanValid, isBreak, isExtended, frameError,
        input  keyUp, keyDown, keyLeft, keyRight
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receive-only PS/2 deframer with E0/F0 prefix decode and held movement keys.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clock50MHz,
    input  logic               resetn,
    ps2_key_decoder_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t          r_state, w_next;
    logic [1:0]      r_clk_sync, r_dat_sync;
    logic            r_clk_prev;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity;
    logic [CW-1:0]   r_idle_cnt;
    logic            r_break_pend, r_ext_pend;
    logic [7:0]      r_held, r_scan_code;
    logic            r_scan_valid, r_is_break, r_is_ext, r_frame_error;
    logic            w_fall, w_dat, w_timeout, w_good, w_bad;
    logic [7:0]      w_mask;
    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != IDLE) && (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1));
    // held bits: [3:0] = W,S,A,D (plain codes), [7:4] = up,down,left,right (E0 codes)
    assign w_mask = {r_ext_pend  & (r_shift == 8'h74), r_ext_pend  & (r_shift == 8'h6B),
                     r_ext_pend  & (r_shift == 8'h72), r_ext_pend  & (r_shift == 8'h75),
                     ~r_ext_pend & (r_shift == 8'h23), ~r_ext_pend & (r_shift == 8'h1C),
                     ~r_ext_pend & (r_shift == 8'h1B), ~r_ext_pend & (r_shift == 8'h1D)};
    always_comb begin
        w_next = r_state;
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (w_timeout) begin
            w_next = IDLE;
            w_bad  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:   w_next = w_dat ? IDLE : DATA;
                DATA:   w_next = (r_bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY: w_next = STOP;
                STOP: begin
                    w_next = IDLE;
                    w_good = w_dat & (^r_shift ^ r_parity);
                    w_bad  = ~w_good;
                end
            endcase
        end
    end
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_parity   <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2Clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2Dat};
            r_clk_prev <= r_clk_sync[1];
            r_state    <= w_next;
            if (w_fall || r_state == IDLE)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != CW'(TIMEOUT_CYCLES - 1))
                r_idle_cnt <= r_idle_cnt + 1'b1;
            if (w_fall && !w_timeout) begin
                if (r_state == IDLE)
                    r_bit_cnt <= 3'd0;
                if (r_state == DATA) begin
                    r_shift   <= {w_dat, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (r_state == PARITY)
                    r_parity <= w_dat;
            end
        end
    end
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            r_scan_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_scan_code   <= 8'h00;
            r_is_break    <= 1'b0;
            r_is_ext      <= 1'b0;
            r_break_pend  <= 1'b0;
            r_ext_pend    <= 1'b0;
            r_held        <= 8'h00;
        end else begin
            r_scan_valid  <= 1'b0;
            r_frame_error <= w_bad;
            if (w_bad) begin
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
            end else if (w_good) begin
                if (r_shift == 8'hF0)
                    r_break_pend <= 1'b1;
                else if (r_shift == 8'hE0)
                    r_ext_pend <= 1'b1;
                else begin
                    r_scan_valid <= 1'b1;
                    r_scan_code  <= r_shift;
                    r_is_break   <= r_break_pend;
                    r_is_ext     <= r_ext_pend;
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                    r_held       <= r_break_pend ? (r_held & ~w_mask) : (r_held | w_mask);
                end
            end
        end
    end
    assign bus.scanCode   = r_scan_code;
    assign bus.scanValid  = r_scan_valid;
    assign bus.isBreak    = r_is_break;
    assign bus.isExtended = r_is_ext;
    assign bus.frameError = r_frame_error;
    assign bus.keyUp      = r_held[0] | r_held[4];
    assign bus.keyDown    = r_held[1] | r_held[5];
    assign bus.keyLeft    = r_held[2] | r_held[6];
    assign bus.keyRight   = r_held[3] | r_held[7];
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

PS/2 keyboard receiver and key-state decoder that sits directly upstream of the raycaster core. It takes the raw `ps2Clk`/`ps2Dat` pad lines, which are open-collector, pulled up, and asynchronous to the system clock. It deframes 11-bit device-to-host frames and decodes the E0/F0 prefixes. It then presents held-key flags for forward/back/left/right movement, plus a per-byte scan-code strobe for any other consumer. The block is receive-only and never drives the PS/2 lines.

## Interface
- `TIMEOUT_CYCLES`, 50000: number of system clocks without a `ps2Clk` falling edge that aborts a partial frame (1 ms at 50 MHz).
- `clock50MHz`  in  1  system clock; all logic is in this domain.
- `resetn`  in  1  reset, asynchronous, active-low.
- `ps2Clk`  in  1  PS/2 clock pad; asynchronous, idle high.
- `ps2Dat`  in  1  PS/2 data pad; asynchronous, idle high.
- `scanCode`  out  8  last decoded non-prefix byte; holds its value between strobes.
- `scanValid`  out  1  one-cycle strobe; `scanCode`, `isBreak` and `isExtended` are valid while it is high.
- `isBreak`  out  1  the byte was preceded by F0.
- `isExtended`  out  1  the byte was preceded by E0.
- `frameError`  out  1  one-cycle strobe on a parity error, stop-bit error, or timeout.
- `keyUp`, `keyDown`, `keyLeft`, `keyRight`  out  1 each  held-key levels.

## Operation
- **Synchronizer:** 2-flop synchronizer on each pad line. A third register holds the previous synced clock value.
  - `fall` = previous & ~current.
  - Data is sampled from the synced `ps2Dat` in the cycle `fall` is high.
- **Receive FSM:** states IDLE, DATA, PARITY, STOP. Every transition occurs only on `fall`, except the timeout.
  - IDLE: if `fall` and data=0, clear `bitCnt` and go to DATA. If `fall` and data=1 (spurious start), stay in IDLE with no error.
  - DATA: shift data into `shiftReg` LSB-first and increment the 3-bit `bitCnt`. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: a frame is good iff stop=1 and (XOR of the 8 data bits) ^ parity = 1, i.e. odd parity.
    - Good frame: hand the byte to the decoder.
    - Bad frame: pulse `frameError`.
    - Either way, return to IDLE.
- **Timeout:** `idleCnt` clears on every `fall` and in IDLE; otherwise it increments.
  - When `idleCnt` = TIMEOUT_CYCLES-1 in a non-IDLE state: go to IDLE, pulse `frameError`, and discard the partial byte.
  - `idleCnt` saturates and does not wrap.
- **Byte decoder** (runs on a good frame):
  - 0xF0: set `breakPend`; no strobe.
  - 0xE0: set `extPend`; no strobe.
  - Any other byte, including 0xAA, 0xFA and 0xE1:
    - pulse `scanValid`, load `scanCode`;
    - set `isBreak` = `breakPend` and `isExtended` = `extPend`;
    - clear both pending flags.
  - Any `frameError` also clears both pending flags.
- **Held bits:** eight internal held bits, set on make and cleared on break.
  - Non-extended: W=1D, S=1B, A=1C, D=23.
  - Extended: up=75, down=72, left=6B, right=74.
  - A code matching the wrong extended-ness, e.g. non-extended 75 (keypad 8), is ignored.
  - Outputs: `keyUp` = W|up, `keyDown` = S|down, `keyLeft` = A|left, `keyRight` = D|right.
  - Opposing keys may both be high; the raycaster arbitrates.
  - Repeated makes (typematic) are idempotent.

## Timing
- **Reset values:** all outputs 0, `scanCode`=0x00. FSM in IDLE; counters, pending flags and held bits cleared. Reset mid-frame discards the partial frame with no strobe.
- **Input latency:** the pad falling edge is seen as `fall` 2–3 clocks later.
- **Output latency:** `scanValid`/`frameError` are registered and go high in the cycle after the STOP-state `fall` (or after the timeout cycle). They stay high exactly 1 cycle.
- **Held keys and `scanCode`** update in the same cycle as `scanValid`.
- **Back-to-back frames:** the minimum PS/2 bit period of 60 µs guarantees that at most one byte is decoded per frame. No buffering is needed; the next frame may start the cycle after STOP.

## Test plan
- **Make, non-extended:** frame 0x1D with parity=1 at a 12.5 kHz PS/2 clock -> one `scanValid` with `scanCode`=0x1D, `isBreak`=0, `isExtended`=0. `keyUp`=1 in the same cycle. `frameError` never asserts.
- **Break:** frames F0, 1D -> exactly one `scanValid` (for 1D) with `isBreak`=1, and `keyUp`=0. No strobe for F0.
- **Extended OR behaviour:**
  - Send W make, then E0 75 -> `isExtended`=1, `keyUp`=1.
  - Then send E0 F0 75 -> `keyUp` stays 1 because W is still held.
  - Then send F0 1D -> `keyUp`=0.
- **Parity error:** 0x1D with parity=0 -> one-cycle `frameError` and no `scanValid`; `keyUp` is unchanged. A pending F0 sent before it is cleared, so a following good 0x1C is a make (`keyLeft`=1).
- **Timeout:** send start bit plus 3 data bits, then hold `ps2Clk` high -> `frameError` pulses exactly TIMEOUT_CYCLES clocks after the last `fall`. A following good 0x23 -> `keyRight`=1.
- **Reset mid-frame:** assert `resetn`=0 after 5 bits -> all outputs 0 immediately (asynchronous). After release, a full 0x1B frame decodes with `keyDown`=1 and no `frameError`.
